// File: rtl/sm2201_camac_pkg.sv
// Shared types and constants for the SM2201 CAMAC station responder: FSM encoding,
// function codes, special register indices and the LAM condition.
package sm2201_camac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_DELAY   = 3'd2,
    ST_RESPOND = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // F codes 4..7 are accepted and handshaken but do nothing
  localparam logic [2:0] F_READ    = 3'd0;
  localparam logic [2:0] F_WRITE   = 3'd1;
  localparam logic [2:0] F_LAM_EN  = 3'd2;
  localparam logic [2:0] F_LAM_CLR = 3'd3;

  localparam logic [3:0] REG_LAM_THRESH = 4'd13;
  localparam logic [3:0] REG_EVENT_CNT  = 4'd14;
  localparam logic [3:0] REG_CONTROL    = 4'd15;

  localparam int unsigned REG_COUNT = 16;

  // cb_addr layout: [11:7]=N, [6:3]=A, [2:0]=F
  typedef struct packed {
    logic [4:0] n;
    logic [3:0] a;
    logic [2:0] f;
  } cmd_t;

  // A threshold of zero disables the request regardless of the counter
  function automatic logic lam_asserted(input logic        en,
                                        input logic [15:0] thresh,
                                        input logic [15:0] count);
    return en && (thresh != 16'd0) && (count >= thresh);
  endfunction

endpackage

// File: rtl/sm2201_camac_station_responder_if.sv
// Board-side CAMAC bus between the ISA interface card (master) and a station responder (slave).
interface sm2201_camac_station_responder_if;
  logic        cb_cx1;
  logic [11:0] cb_addr;
  logic [15:0] cb_data_i;
  logic [15:0] cb_data_o;
  logic        cb_data_oe;
  logic        cb_prr;
  logic        cb_zk4;

  modport master (
    output cb_cx1, cb_addr, cb_data_i,
    input  cb_data_o, cb_data_oe, cb_prr, cb_zk4
  );

  modport slave (
    input  cb_cx1, cb_addr, cb_data_i,
    output cb_data_o, cb_data_oe, cb_prr, cb_zk4
  );
endinterface

// File: rtl/sm2201_camac_regfile.sv
// 16x16 station register file with one write port, one read port and the
// lam_event counter in reg[14]; fixed taps expose the LAM threshold and counter.
module sm2201_camac_regfile
  import sm2201_camac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr,
  output logic [15:0] rdata,
  input  logic        inc,
  output logic [15:0] thresh,
  output logic [15:0] count
);

  logic [15:0] mem [REG_COUNT];

  // NOTE: the whole array is reset, so this maps to flops rather than a RAM macro;
  // software relies on every register reading zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) mem[i] <= '0;
    end else begin
      if (inc) mem[REG_EVENT_CNT] <= mem[REG_EVENT_CNT] + 16'd1;
      // NOTE: the later non-blocking assignment to the same element wins, so a
      // bus write to reg[14] overrides a coincident counter increment.
      if (we)  mem[waddr] <= wdata;
    end
  end

  assign rdata  = mem[raddr];
  assign thresh = mem[REG_LAM_THRESH];
  assign count  = mem[REG_EVENT_CNT];

endmodule

// File: rtl/sm2201_camac_station_responder.sv
// CAMAC station responder: decodes strobed N.A.F commands from the interface board,
// services the register file and raises LAM when the event counter reaches threshold.
module sm2201_camac_station_responder
  import sm2201_camac_pkg::*;
#(
  parameter logic [4:0] STATION_N  = 5'd1,
  parameter logic [7:0] RESP_DELAY = 8'd3,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic                             isa_clk,
  input  logic                             isa_reset,
  sm2201_camac_station_responder_if.slave  cb,
  input  logic                             lam_event,
  output logic                             timeout_err
);

  logic        cx_s1, cx_s2, cx_prev, cx_fall;
  state_t      state, state_nxt;
  cmd_t        cmd;
  logic [15:0] wdata_q;
  logic [7:0]  cnt;
  logic        lam_en;
  logic [15:0] data_q;
  logic        station_hit, decode_hit, timeout_hit, reg_we, is_read;
  logic [15:0] rd_data, lam_thresh, event_cnt;
  logic        prr, data_oe;

  // Synchroniser and edge history reset high so a released reset never looks like a strobe.
  // NOTE: sequential state uses <= so each flop samples its pre-edge input; with =
  // the three stages would collapse into a single flop.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      cx_s1   <= 1'b1;
      cx_s2   <= 1'b1;
      cx_prev <= 1'b1;
    end else begin
      cx_s1   <= cb.cb_cx1;
      cx_s2   <= cx_s1;
      cx_prev <= cx_s2;
    end
  end

  assign cx_fall = cx_prev & ~cx_s2;

  // Command and write data are captured in the clock the strobe edge is seen
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      cmd     <= '0;
      wdata_q <= '0;
    end else if (state == ST_IDLE && cx_fall) begin
      cmd     <= cmd_t'(cb.cb_addr);
      wdata_q <= cb.cb_data_i;
    end
  end

  assign station_hit = (cmd.n == STATION_N);
  assign decode_hit  = (state == ST_DECODE) && station_hit;
  assign reg_we      = decode_hit && (cmd.f == F_WRITE);
  assign is_read     = (cmd.f == F_READ);
  assign timeout_hit = (state == ST_RESPOND) && !cx_s2 && (cnt >= TIMEOUT);

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cx_fall) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!station_hit)             state_nxt = ST_IDLE;
        else if (RESP_DELAY == 8'd0)  state_nxt = ST_RESPOND;
        else                          state_nxt = ST_DELAY;
      end
      ST_DELAY:   if (cnt >= RESP_DELAY) state_nxt = ST_RESPOND;
      // Strobe release has priority over an expiring timeout in the same clock
      ST_RESPOND: if (cx_s2 || cnt >= TIMEOUT) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    prr     = 1'b1;
    data_oe = 1'b0;
    case (state)
      ST_DELAY:   data_oe = is_read;
      ST_RESPOND: begin
        prr     = 1'b0;
        data_oe = is_read;
      end
      ST_RELEASE: data_oe = is_read;
      default:    ;
    endcase
  end

  // One counter serves both the response delay and the strobe timeout; it restarts at 1
  // on every state change so its value is the number of clocks spent in the current state.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= 8'd1;
    end else if (state == ST_DELAY || state == ST_RESPOND) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      data_q      <= '0;
      lam_en      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (decode_hit && cmd.f == F_READ)    data_q <= rd_data;
      if (decode_hit && cmd.f == F_LAM_EN)  lam_en <= 1'b1;
      if (decode_hit && cmd.f == F_LAM_CLR) lam_en <= 1'b0;
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (reg_we && cmd.a == REG_CONTROL && wdata_q[0]) begin
        timeout_err <= 1'b0;
      end
    end
  end

  sm2201_camac_regfile u_regfile (
    .clk    (isa_clk),
    .rst_n  (isa_reset),
    .we     (reg_we),
    .waddr  (cmd.a),
    .wdata  (wdata_q),
    .raddr  (cmd.a),
    .rdata  (rd_data),
    .inc    (lam_event),
    .thresh (lam_thresh),
    .count  (event_cnt)
  );

  assign cb.cb_prr     = prr;
  assign cb.cb_data_oe = data_oe;
  assign cb.cb_data_o  = data_q;
  assign cb.cb_zk4     = ~lam_asserted(lam_en, lam_thresh, event_cnt);

endmodule

// File: tb/tb_sm2201_camac_station_responder.sv
// Self-checking bench: a transaction-level timeline model predicts every output per clock
// and a compare process checks the DUT on each falling edge.
module tb_sm2201_camac_station_responder;

  localparam logic [4:0] STN   = 5'd1;
  localparam int         RD    = 3;
  localparam int         TO    = 255;
  localparam int         NEVER = 1 << 30;

  logic isa_clk     = 1'b0;
  logic isa_reset   = 1'b0;
  logic lam_event   = 1'b0;
  logic timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  sm2201_camac_station_responder_if cb();

  sm2201_camac_station_responder #(
    .STATION_N  (STN),
    .RESP_DELAY (8'(RD)),
    .TIMEOUT    (8'(TO))
  ) dut (
    .isa_clk     (isa_clk),
    .isa_reset   (isa_reset),
    .cb          (cb),
    .lam_event   (lam_event),
    .timeout_err (timeout_err)
  );

  always #5 isa_clk = ~isa_clk;

  // Model: register contents plus the edge numbers at which scheduled effects land
  logic [15:0] m_reg [16];
  bit          m_lam_en, m_terr;
  int          edge_no;
  int          wr_edge, lamen_edge, rd_edge, to_edge, force_lam_edge;
  logic [3:0]  wr_a, rd_a;
  logic [15:0] wr_d;
  bit          lamen_val;
  int          prr_from, prr_to, oe_from, oe_to;
  bit          lam_rand = 1'b0;
  bit          cmp_en   = 1'b0;
  logic        exp_prr, exp_oe, exp_zk4, exp_terr;
  logic [15:0] exp_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, got, want, edge_no);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_lam_en = 1'b0;
    m_terr   = 1'b0;
    wr_edge = -1; lamen_edge = -1; rd_edge = -1; to_edge = -1; force_lam_edge = -1;
    prr_from = -1; prr_to = -1; oe_from = -1; oe_to = -1;
    exp_data = '0;
  endtask

  // Advance one clock, apply the model effects of that edge, then drive lam_event for the next one
  task automatic tick();
    bit ev, live;
    ev   = lam_event;
    live = isa_reset;
    @(posedge isa_clk);
    #1;
    edge_no++;
    if (live) begin
      if (ev && !(edge_no == wr_edge && wr_a == 4'd14)) m_reg[14] = m_reg[14] + 16'd1;
      if (edge_no == wr_edge) begin
        m_reg[wr_a] = wr_d;
        if (wr_a == 4'd15 && wr_d[0]) m_terr = 1'b0;
      end
      if (edge_no == lamen_edge) m_lam_en = lamen_val;
      if (edge_no == to_edge)    m_terr   = 1'b1;
      if (edge_no == rd_edge)    exp_data = m_reg[rd_a];
    end
    exp_prr  = !(edge_no >= prr_from && edge_no < prr_to);
    exp_oe   = (edge_no >= oe_from && edge_no < oe_to);
    exp_zk4  = !(m_lam_en && m_reg[13] != 16'd0 && m_reg[14] >= m_reg[13]);
    exp_terr = m_terr;
    lam_event = (edge_no + 1 == force_lam_edge) || (lam_rand && $urandom_range(7) == 0);
  endtask

  always @(negedge isa_clk) begin
    if (cmp_en) begin
      check("cb_prr",      32'(cb.cb_prr),     32'(exp_prr));
      check("cb_data_oe",  32'(cb.cb_data_oe), 32'(exp_oe));
      check("cb_zk4",      32'(cb.cb_zk4),     32'(exp_zk4));
      check("timeout_err", 32'(timeout_err),   32'(exp_terr));
      if (exp_oe) check("cb_data_o", 32'(cb.cb_data_o), 32'(exp_data));
    end
  end

  // One strobed command. hold = clocks the strobe stays low after RESPOND is entered
  // (or after decode for another station); hold >= TO exercises the timeout.
  task automatic camac(input logic [4:0] n, input logic [3:0] a, input logic [2:0] f,
                       input logic [15:0] d, input int hold, input bit collide,
                       output int first_low, output int low_cnt, output logic [15:0] rd_val);
    int t0, p, r;
    bit hit;
    t0 = edge_no;
    hit = (n == STN);
    first_low = -1;
    low_cnt = 0;
    rd_val = '0;
    prr_from = -1; prr_to = -1; oe_from = -1; oe_to = -1;
    cb.cb_cx1 = 1'b0;
    cb.cb_addr = {n, a, f};
    cb.cb_data_i = d;
    if (collide) force_lam_edge = t0 + 4;
    // Edge t0+3 is the clock the synchronised falling edge is seen
    if (!hit) begin
      r = t0 + 3 + hold;
    end else begin
      p = t0 + 4 + RD;
      prr_from = p;
      if (f == 3'd1) begin wr_edge = t0 + 4; wr_a = a; wr_d = d; end
      if (f == 3'd2 || f == 3'd3) begin lamen_edge = t0 + 4; lamen_val = (f == 3'd2); end
      if (f == 3'd0) begin rd_edge = t0 + 3; rd_a = a; oe_from = t0 + 4; end
      r = p + hold;
      if (hold >= TO) begin
        prr_to  = p + TO;
        to_edge = p + TO;
        if (f == 3'd0) oe_to = p + TO + 1;
      end else begin
        prr_to = r + 3;
        if (f == 3'd0) oe_to = r + 4;
      end
    end
    while (edge_no < r + 4) begin
      if (edge_no >= r) cb.cb_cx1 = 1'b1;
      tick();
      if (cb.cb_prr === 1'b0) begin
        low_cnt++;
        if (first_low < 0) begin
          first_low = edge_no - (t0 + 3);
          rd_val = cb.cb_data_o;
        end
      end
    end
  endtask

  initial begin
    int          fl, lc, t0;
    logic [15:0] rv;
    logic [4:0]  n;
    logic [2:0]  f;
    logic [3:0]  a;

    model_clear();
    edge_no = 0;
    cb.cb_cx1 = 1'b1;
    cb.cb_addr = '0;
    cb.cb_data_i = '0;
    repeat (3) tick();
    isa_reset = 1'b1;
    tick();
    check("rst_prr",    32'(cb.cb_prr),     32'd1);
    check("rst_oe",     32'(cb.cb_data_oe), 32'd0);
    check("rst_data_o", 32'(cb.cb_data_o),  32'd0);
    check("rst_zk4",    32'(cb.cb_zk4),     32'd1);
    check("rst_terr",   32'(timeout_err),   32'd0);
    cmp_en = 1'b1;
    repeat (2) tick();

    // Write then read back with the response latency pinned
    camac(STN, 4'd3, 3'd1, 16'hA5C3, 2, 1'b0, fl, lc, rv);
    camac(STN, 4'd3, 3'd0, 16'h0000, 2, 1'b0, fl, lc, rv);
    check("read_latency",    32'(fl), 32'd4);
    check("read_a3",         32'(rv), 32'hA5C3);
    check("read_low_clocks", 32'(lc), 32'd5);

    // Another station's command must leave everything untouched
    camac(5'd2, 4'd3, 3'd1, 16'h1234, 2, 1'b0, fl, lc, rv);
    check("miss_no_prr", 32'(lc), 32'd0);
    camac(STN, 4'd3, 3'd0, 16'h0000, 1, 1'b0, fl, lc, rv);
    check("miss_reg_kept", 32'(rv), 32'hA5C3);

    // LAM at threshold 3
    camac(STN, 4'd13, 3'd1, 16'd3, 0, 1'b0, fl, lc, rv);
    camac(STN, 4'd0,  3'd2, 16'd0, 0, 1'b0, fl, lc, rv);
    lam_event = 1'b1; tick(); tick();
    lam_event = 1'b1; tick(); tick();
    check("lam_below_thresh", 32'(cb.cb_zk4), 32'd1);
    lam_event = 1'b1; tick();
    check("lam_at_thresh", 32'(cb.cb_zk4), 32'd0);
    camac(STN, 4'd0, 3'd3, 16'd0, 1, 1'b0, fl, lc, rv);
    check("lam_cleared", 32'(cb.cb_zk4), 32'd1);

    // Counter wrap, then write colliding with an event
    camac(STN, 4'd14, 3'd1, 16'hFFFF, 0, 1'b0, fl, lc, rv);
    lam_event = 1'b1; tick();
    camac(STN, 4'd14, 3'd0, 16'h0000, 0, 1'b0, fl, lc, rv);
    check("cnt_wrap", 32'(rv), 32'h0000);
    camac(STN, 4'd14, 3'd1, 16'h0010, 0, 1'b1, fl, lc, rv);
    camac(STN, 4'd14, 3'd0, 16'h0000, 0, 1'b0, fl, lc, rv);
    check("cnt_collide", 32'(rv), 32'h0010);

    // Strobe held low 300 clocks: forced release after 255, no retrigger
    camac(STN, 4'd7, 3'd4, 16'h0000, 300 - 4 - RD, 1'b0, fl, lc, rv);
    check("timeout_low_clocks", 32'(lc), 32'd255);
    check("timeout_err_set",    32'(timeout_err), 32'd1);
    repeat (20) tick();
    check("no_second_response", 32'(cb.cb_prr), 32'd1);
    camac(STN, 4'd15, 3'd1, 16'h0001, 1, 1'b0, fl, lc, rv);
    check("timeout_err_clear", 32'(timeout_err), 32'd0);

    // Random commands with background events
    lam_rand = 1'b1;
    repeat (80) begin
      n = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : STN;
      a = 4'($urandom_range(15));
      f = 3'($urandom_range(7));
      camac(n, a, f, 16'($urandom), $urandom_range(6), 1'b0, fl, lc, rv);
      repeat ($urandom_range(3)) tick();
    end
    lam_rand = 1'b0;
    tick();
    camac(STN, 4'd3, 3'd1, 16'h5A5A, 0, 1'b0, fl, lc, rv);

    // Reset pulled in the middle of a read response
    t0 = edge_no;
    prr_from = -1; prr_to = -1; oe_from = -1; oe_to = -1;
    cb.cb_cx1 = 1'b0;
    cb.cb_addr = {STN, 4'd3, 3'd0};
    rd_edge = t0 + 3; rd_a = 4'd3;
    oe_from = t0 + 4; oe_to = NEVER;
    prr_from = t0 + 4 + RD; prr_to = NEVER;
    while (edge_no < t0 + 5 + RD) tick();
    check("pre_reset_prr", 32'(cb.cb_prr), 32'd0);
    #2;
    cmp_en = 1'b0;
    isa_reset = 1'b0;
    #1;
    check("midrst_prr",    32'(cb.cb_prr),     32'd1);
    check("midrst_oe",     32'(cb.cb_data_oe), 32'd0);
    check("midrst_data_o", 32'(cb.cb_data_o),  32'd0);
    check("midrst_zk4",    32'(cb.cb_zk4),     32'd1);
    model_clear();
    cb.cb_cx1 = 1'b1;
    repeat (3) tick();
    isa_reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      camac(STN, 4'(i), 3'd0, 16'h0000, 0, 1'b0, fl, lc, rv);
      check("reset_reg_zero", 32'(rv), 32'd0);
    end

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
